debounce_bank: RTL and testbench

Parametrised multi-channel button conditioner for the board front panel: it sits between the raw pad inputs and the game/control logic. Each channel is synchronised into `clk`, then debounced against a shared prescaled tick. Each channel produces a clean level, one-cycle press and release pulses, and an optional auto-repeat hold pulse. It generalises the single-button debouncer to N channels with programmable time base, idle polarity and edge outputs.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_tick.sv | 24 ++
 rtl/debounce_bank.sv | 131 +++++++++++++
 tb/tb_debounce_bank.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and the per-channel debounce state encoding for debounce_bank.
package debounce_pkg;

  localparam int unsigned DEF_PRESCALE     = 500;
  localparam int unsigned DEF_STABLE_TICKS = 200;
  localparam int unsigned DEF_HOLD_TICKS   = 1000;
  localparam int unsigned DEF_REPEAT_TICKS = 250;

  // ST_IDLE: level equals the channel's released level; ST_ACTIVE: it differs.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic level_of(state_t st, logic idle_bit);
    return idle_bit ^ (st == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/debounce_tick.sv
// Shared prescaler: counts 0..PRESCALE-1 and asserts tick on the last count.
module debounce_tick
  import debounce_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned PRE_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [PRE_BITS-1:0] count_q;

  assign tick = (count_q == PRE_BITS'(PRESCALE - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count_q <= '0;
    else if (tick) count_q <= '0;
    else           count_q <= count_q + 1'b1;
  end

endmodule

// File: rtl/debounce_bank.sv
// N-channel button conditioner: 2-flop sync, tick-based debounce, press/release pulses.
// Define DEBOUNCE_HOLD_EN to build the per-channel auto-repeat hold pulse generator.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned           CHANNELS     = 5,
  parameter int unsigned           PRESCALE     = DEF_PRESCALE,
  parameter int unsigned           PRE_BITS     = 16,
  parameter int unsigned           STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned           CNT_BITS     = 8,
  parameter logic [CHANNELS-1:0]   IDLE_LEVEL   = {CHANNELS{1'b0}},
  parameter int unsigned           HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int unsigned           REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int unsigned           HOLD_BITS    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_hold
);

  if (CHANNELS < 1 || PRESCALE < 1 || STABLE_TICKS < 1 ||
      longint'(PRESCALE - 1) >= (longint'(1) << PRE_BITS) ||
      longint'(STABLE_TICKS - 1) >= (longint'(1) << CNT_BITS) ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > HOLD_TICKS ||
      longint'(HOLD_TICKS) >= (longint'(1) << HOLD_BITS)) begin : g_bad_params
    $error("debounce_bank: illegal parameter combination");
  end

  logic tick;

  debounce_tick #(
    .PRESCALE (PRESCALE),
    .PRE_BITS (PRE_BITS)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic IDLE_BIT = IDLE_LEVEL[i];

    logic                s1_q, s2_q;
    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                flip, flip_q;
    logic                press_q, release_q;
    logic                level;

    assign level          = level_of(state_q, IDLE_BIT);
    assign btn_level[i]   = level;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        // NOTE: sync flops reset to the idle level so reset release never looks like an edge.
        s1_q      <= IDLE_BIT;
        s2_q      <= IDLE_BIT;
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        flip_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= btn_in[i];
        s2_q      <= s1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        flip_q    <= flip;
        // Pulses trail the level change by one cycle.
        press_q   <= flip_q && (state_q == ST_ACTIVE);
        release_q <= flip_q && (state_q == ST_IDLE);
      end
    end

    always_comb begin
      // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      flip    = 1'b0;
      if (s2_q == level) begin
        cnt_d = '0;
      end else if (tick) begin
        if (cnt_q == CNT_BITS'(STABLE_TICKS - 1)) begin
          flip    = 1'b1;
          cnt_d   = '0;
          state_d = (state_q == ST_IDLE) ? ST_ACTIVE : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

`ifdef DEBOUNCE_HOLD_EN
    logic [HOLD_BITS-1:0] hold_cnt_q;
    logic                 hold_fire_q, hold_q;

    assign btn_hold[i] = hold_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_cnt_q  <= '0;
        hold_fire_q <= 1'b0;
        hold_q      <= 1'b0;
      end else begin
        hold_fire_q <= 1'b0;
        // A release on this tick pre-empts any hold firing.
        if (state_q != ST_ACTIVE || flip) begin
          hold_cnt_q <= '0;
        end else if (tick) begin
          if (hold_cnt_q == HOLD_BITS'(HOLD_TICKS - 1)) begin
            hold_fire_q <= 1'b1;
            hold_cnt_q  <= HOLD_BITS'(HOLD_TICKS - REPEAT_TICKS);
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        hold_q <= hold_fire_q && (state_q == ST_ACTIVE);
      end
    end
`else
    assign btn_hold[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: vector table plus scoreboard of expected level changes.
`timescale 1ns/1ps
module tb_debounce_bank;

  localparam logic [1:0] IDLE = 2'b10;

  logic       clk;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] btn_level, btn_press, btn_release, btn_hold;

  debounce_bank #(
    .CHANNELS     (2),
    .PRESCALE     (4),
    .PRE_BITS     (16),
    .STABLE_TICKS (3),
    .CNT_BITS     (8),
    .IDLE_LEVEL   (IDLE),
    .HOLD_TICKS   (5),
    .REPEAT_TICKS (2),
    .HOLD_BITS    (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_hold    (btn_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected level changes, pushed when an input edge is driven.
  typedef struct {
    int   ch;
    logic lvl;
    int   drv;
  } exp_t;
  exp_t sb[$];

  logic [1:0] exp_lvl;
  logic [1:0] idle_v = IDLE;

  task automatic sb_match(int c, logic l);
    int idx = -1;
    int lat;
    for (int k = 0; k < sb.size(); k++)
      if (idx < 0 && sb[k].ch == c) idx = k;
    n_cmp++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: ch%0d level went to %0b at cycle %0d, no change expected", c, l, cyc);
    end else begin
      lat = cyc - sb[idx].drv;
      if (lat < 11 || lat > 14 || sb[idx].lvl != l) begin
        n_fail++;
        $display("FAIL sb_latency: ch%0d level %0b after %0d cycles, expected level %0b after 11..14",
                 c, l, lat, sb[idx].lvl);
      end
      sb.delete(idx);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active clock edge.
  logic [1:0] lvl_prev = IDLE;
  int chg_cyc[2]   = '{0, 0};
  int press_cyc[2] = '{0, 0};
  int n_press[2]   = '{0, 0};
  int n_rel[2]     = '{0, 0};
  int n_hold       = 0;
  int hold_log[$];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        if (btn_level[c] != lvl_prev[c]) begin
          sb_match(c, btn_level[c]);
          chg_cyc[c] = cyc;
        end
        if (btn_press[c]) begin
          n_press[c]++;
          press_cyc[c] = cyc;
          check($sformatf("press_align_ch%0d", c), cyc - chg_cyc[c], 1);
          check($sformatf("press_dir_ch%0d", c), int'(btn_level[c] ^ idle_v[c]), 1);
        end
        if (btn_release[c]) begin
          n_rel[c]++;
          check($sformatf("release_align_ch%0d", c), cyc - chg_cyc[c], 1);
          check($sformatf("release_dir_ch%0d", c), int'(btn_level[c] ^ idle_v[c]), 0);
        end
        if (btn_hold[c]) begin
          n_hold++;
          if (c == 0) hold_log.push_back(cyc);
          check($sformatf("hold_active_ch%0d", c), int'(btn_level[c] ^ idle_v[c]), 1);
          check($sformatf("hold_vs_release_ch%0d", c), int'(btn_release[c]), 0);
        end
      end
    end
    lvl_prev = btn_level;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(logic [1:0] v, logic [1:0] lvl);
    for (int c = 0; c < 2; c++)
      if (lvl[c] != exp_lvl[c]) sb.push_back('{c, lvl[c], cyc});
    exp_lvl = lvl;
    btn_in  = v;
  endtask

  task automatic check_counts(string tag, int p0, int p1, int r0, int r1);
    check({tag, "_press0"},   n_press[0], p0);
    check({tag, "_press1"},   n_press[1], p1);
    check({tag, "_release0"}, n_rel[0],   r0);
    check({tag, "_release1"}, n_rel[1],   r1);
  endtask

  typedef struct {
    logic [1:0] in;
    int         cycles;
    logic [1:0] lvl;
    int         p0, p1, r0, r1;
  } vec_t;
  vec_t vt[7];

  initial begin
    int p, r, nexp, h;

    vt[0] = '{2'b10, 20, 2'b10, 0, 0, 0, 0};  // idle after reset
    vt[1] = '{2'b11, 40, 2'b11, 1, 0, 0, 0};  // clean press ch0
    vt[2] = '{2'b10, 30, 2'b10, 1, 0, 1, 0};  // release ch0
    vt[3] = '{2'b00, 30, 2'b00, 1, 1, 1, 0};  // active-low ch1 press
    vt[4] = '{2'b10, 30, 2'b10, 1, 1, 1, 1};  // ch1 release
    vt[5] = '{2'b01, 30, 2'b01, 2, 2, 1, 1};  // simultaneous press
    vt[6] = '{2'b10, 30, 2'b10, 2, 2, 2, 2};  // simultaneous release

    // Reset with a non-idle input present.
    reset   = 1'b0;
    btn_in  = 2'b01;
    exp_lvl = IDLE;
    repeat (5) @(posedge clk);
    #1;
    check("rst_level",   btn_level,   IDLE);
    check("rst_press",   btn_press,   0);
    check("rst_release", btn_release, 0);
    check("rst_hold",    btn_hold,    0);
    step(1);
    reset  = 1'b1;
    btn_in = 2'b10;

    for (int i = 0; i < 7; i++) begin
      step(1);
      drive(vt[i].in, vt[i].lvl);
      repeat (vt[i].cycles) @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d_level", i), btn_level, vt[i].lvl);
      check($sformatf("row%0d_pending", i), sb.size(), 0);
      check_counts($sformatf("row%0d", i), vt[i].p0, vt[i].p1, vt[i].r0, vt[i].r1);
    end
    check("simultaneous_flip", chg_cyc[0] - chg_cyc[1], 0);

    // Bounce on ch0: 4 cycles high, 1-cycle low glitch, twelve times, then stable high.
    step(1);
    for (int g = 0; g < 12; g++) begin
      btn_in[0] = 1'b1;
      step(4);
      btn_in[0] = 1'b0;
      step(1);
    end
    check("bounce_level", btn_level, 2'b10);
    drive(2'b11, 2'b11);
    step(30);
    check("bounce_pending", sb.size(), 0);
    check("bounce_level_final", btn_level, 2'b11);
    check_counts("bounce", 3, 2, 2, 2);
    drive(2'b10, 2'b10);
    step(30);
    check_counts("bounce_rel", 3, 2, 3, 2);

    // Long hold on ch0.
    hold_log.delete();
    drive(2'b11, 2'b11);
    step(100);
    drive(2'b10, 2'b10);
    step(40);
    check("hold_pending", sb.size(), 0);
`ifdef DEBOUNCE_HOLD_EN
    p    = press_cyc[0];
    r    = chg_cyc[0];
    nexp = 0;
    for (h = p + 20; h <= r; h += 8) begin
      if (nexp < hold_log.size())
        check($sformatf("hold_cyc%0d", nexp), hold_log[nexp], h);
      nexp++;
    end
    check("hold_count", hold_log.size(), nexp);
`else
    p = 0; r = 0; nexp = 0; h = 0;
    check("hold_tied_off", hold_log.size(), 0);
`endif
    check_counts("hold", 4, 2, 4, 2);

    // Reset in the middle of a stability window.
    btn_in = 2'b11;
    step(8);
    reset = 1'b0;
    #1;
    check("midwin_level", btn_level, IDLE);
    step(3);
    btn_in  = 2'b10;
    exp_lvl = IDLE;
    reset   = 1'b1;
    step(30);
    check("midwin_level_after", btn_level, IDLE);
    check_counts("midwin", 4, 2, 4, 2);

    // Reset while the channel is active (and repeating when hold is built).
    drive(2'b11, 2'b11);
    step(60);
    check("midhold_level", btn_level, 2'b11);
    check("midhold_pending", sb.size(), 0);
    reset = 1'b0;
    #1;
    check("midhold_rst_level",   btn_level,   IDLE);
    check("midhold_rst_press",   btn_press,   0);
    check("midhold_rst_release", btn_release, 0);
    check("midhold_rst_hold",    btn_hold,    0);
    step(3);
    btn_in  = 2'b10;
    exp_lvl = IDLE;
    reset   = 1'b1;
    step(30);
    check_counts("midhold", 5, 2, 4, 2);
`ifndef DEBOUNCE_HOLD_EN
    check("hold_never", n_hold, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
